// File: rtl/ahb_arb_if.sv
// Bus bundle between the masters' request side and the round-robin AHB-Lite arbiter.
// Per-master fields are packed with master i at the low-order slice i.
interface ahb_arb_if #(
  parameter int NUM_MASTERS = 3,
  parameter int MW          = 2
);
  logic [2*NUM_MASTERS-1:0] HTRANS_M;
  logic [3*NUM_MASTERS-1:0] HBURST_M;
  logic [NUM_MASTERS-1:0]   HMASTLOCK_M;
  logic                     HREADY;
  logic [MW-1:0]            HMASTER;
  logic [MW-1:0]            HMASTER_D;
  logic                     HMASTLOCK;
  logic [NUM_MASTERS-1:0]   HREADYOUT_M;

  // Arbiter side.
  modport slave (
    input  HTRANS_M, HBURST_M, HMASTLOCK_M, HREADY,
    output HMASTER, HMASTER_D, HMASTLOCK, HREADYOUT_M
  );

  // Requester side.
  modport master (
    output HTRANS_M, HBURST_M, HMASTLOCK_M, HREADY,
    input  HMASTER, HMASTER_D, HMASTLOCK, HREADYOUT_M
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter: address-phase owner, data-phase owner,
// burst/lock hold and per-master HREADY stalling.
module ahb_arb_port #(
  parameter int MW  = 2,
  parameter int IDX = 0
) (
  input  logic [MW-1:0] hmaster,
  input  logic [MW-1:0] hmaster_d,
  input  logic          req,
  input  logic          hready,
  output logic          hreadyout
);
  // Owners in either phase see the real bus ready; others stall while requesting.
  always_comb begin
    if (hmaster == IDX[MW-1:0] || hmaster_d == IDX[MW-1:0]) hreadyout = hready;
    else                                                    hreadyout = ~req;
  end
endmodule

module ahb_master_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic      HCLK,
  input  logic      HRESETn,
  ahb_arb_if.slave  bus
);
  localparam int NP = 1 << MW;

  logic [1:0]    trans [NP];
  logic [2:0]    burst [NP];
  logic [NP-1:0] lock;

  logic [MW-1:0] hmaster_q, hmaster_d_q, hmaster_nxt;
  logic [3:0]    cnt_q, cnt_nxt;
  logic [1:0]    g_trans;
  logic [2:0]    g_burst;
  logic          hold, found;

  // Pad to a power of two so any MW-bit index selects a defined (idle) slot.
  for (genvar g = 0; g < NP; g++) begin : g_unpack
    if (g < NUM_MASTERS) begin : g_real
      assign trans[g] = bus.HTRANS_M[2*g+1:2*g];
      assign burst[g] = bus.HBURST_M[3*g+2:3*g];
      assign lock[g]  = bus.HMASTLOCK_M[g];
    end else begin : g_pad
      assign trans[g] = 2'b00;
      assign burst[g] = 3'b000;
      assign lock[g]  = 1'b0;
    end
  end

  assign g_trans = trans[hmaster_q];
  assign g_burst = burst[hmaster_q];
  // BUSY and SEQ both have bit 0 set; either keeps the grant.
  assign hold    = lock[hmaster_q] | (cnt_q != 4'd0) | g_trans[0];

  always_comb begin
    cnt_nxt = cnt_q;
    case (g_trans)
      2'b10: begin
        case (g_burst[2:1])
          2'b01:   cnt_nxt = 4'd3;
          2'b10:   cnt_nxt = 4'd7;
          2'b11:   cnt_nxt = 4'd15;
          default: cnt_nxt = 4'd0;
        endcase
      end
      2'b11:   cnt_nxt = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      2'b00:   cnt_nxt = 4'd0;
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_comb begin
    hmaster_nxt = hmaster_q;
    found       = 1'b0;
    for (int k = 1; k < NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(hmaster_q) + k) % NUM_MASTERS;
      if (!found && trans[idx][1]) begin
        hmaster_nxt = idx[MW-1:0];
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hmaster_q   <= DEFAULT_MASTER[MW-1:0];
      hmaster_d_q <= DEFAULT_MASTER[MW-1:0];
      cnt_q       <= 4'd0;
    end else if (bus.HREADY) begin
      hmaster_d_q <= hmaster_q;
      cnt_q       <= cnt_nxt;
      if (!hold) hmaster_q <= hmaster_nxt;
    end
  end

  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTER_D = hmaster_d_q;
  assign bus.HMASTLOCK = lock[hmaster_q];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
    ahb_arb_port #(.MW(MW), .IDX(g)) u_port (
      .hmaster   (hmaster_q),
      .hmaster_d (hmaster_d_q),
      .req       (trans[g][1]),
      .hready    (bus.HREADY),
      .hreadyout (bus.HREADYOUT_M[g])
    );
  end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_ahb_master_arbiter;
  localparam int N  = 3;
  localparam int MW = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_arb_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

  ahb_master_arbiter #(.NUM_MASTERS(N), .MW(MW), .DEFAULT_MASTER(0)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  logic [1:0]   tr [N];
  logic [2:0]   bu [N];
  logic [N-1:0] lk;
  logic         hr;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.HTRANS_M[2*i +: 2] = tr[i];
      bus.HBURST_M[3*i +: 3] = bu[i];
    end
    bus.HMASTLOCK_M = lk;
    bus.HREADY      = hr;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns each phase and how many beats of the owner's burst remain.
  typedef struct packed { int own; int down; int left; } model_t;
  model_t m = '{own: 0, down: 0, left: 0};

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic model_t next_model(input model_t s);
    model_t r;
    int     t;
    bit     keep;
    r = s;
    if (!HRESETn) return '{own: 0, down: 0, left: 0};
    if (!hr) return s;
    t    = int'(tr[s.own]);
    keep = lk[s.own] || s.left != 0 || t == 1 || t == 3;
    if (t == 2)      r.left = burst_beats(bu[s.own]) - 1;
    else if (t == 3) r.left = (s.left > 0) ? s.left - 1 : 0;
    else if (t == 0) r.left = 0;
    r.down = s.own;
    if (!keep) begin
      for (int k = 1; k < N; k++) begin
        int c;
        c = (s.own + k) % N;
        if (tr[c] >= 2) begin
          r.own = c;
          break;
        end
      end
    end
    return r;
  endfunction

  always @(posedge HCLK) m <= next_model(m);

  always @(negedge HCLK) begin
    if (chk_en) begin
      logic [N-1:0] exp_ro;
      for (int i = 0; i < N; i++)
        exp_ro[i] = (i == m.own || i == m.down) ? hr : ~tr[i][1];
      chk("cyc_hmaster",   32'(bus.HMASTER),     32'(m.own));
      chk("cyc_hmaster_d", 32'(bus.HMASTER_D),   32'(m.down));
      chk("cyc_hmastlock", 32'(bus.HMASTLOCK),   32'(lk[m.own]));
      chk("cyc_hreadyout", 32'(bus.HREADYOUT_M), 32'(exp_ro));
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic all_idle();
    for (int i = 0; i < N; i++) begin
      tr[i] = 2'b00;
      bu[i] = 3'b000;
    end
    lk = '0;
  endtask

  initial begin
    all_idle();
    hr      = 1'b1;
    HRESETn = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    HRESETn = 1'b1;

    // 1: parked on default master while everyone is idle
    repeat (10) step();
    chk("t1_hmaster",   32'(bus.HMASTER),     32'd0);
    chk("t1_hmaster_d", 32'(bus.HMASTER_D),   32'd0);
    chk("t1_hreadyout", 32'(bus.HREADYOUT_M), 32'b111);

    // 2: M1 request, one-cycle stall then grant, data phase follows
    tr[1] = 2'b10;
    #1;
    chk("t2_stall", 32'(bus.HREADYOUT_M[1]), 32'd0);
    step();
    chk("t2_hmaster",   32'(bus.HMASTER),   32'd1);
    chk("t2_hmaster_d", 32'(bus.HMASTER_D), 32'd0);
    chk("t2_ready1",    32'(bus.HREADYOUT_M[1]), 32'd1);
    tr[1] = 2'b00;
    step();
    chk("t2_hmaster_d2", 32'(bus.HMASTER_D), 32'd1);

    // 3: M0 INCR4 holds grant, then round-robin 1 -> 2
    tr[0] = 2'b10;
    step();
    chk("t3_own0", 32'(bus.HMASTER), 32'd0);
    bu[0] = 3'b011;
    step();
    tr[0] = 2'b11; tr[1] = 2'b10; tr[2] = 2'b10;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("t3_hold", 32'(bus.HMASTER), 32'd0);
    end
    tr[0] = 2'b00;
    step();
    chk("t3_to1", 32'(bus.HMASTER), 32'd1);
    step();
    chk("t3_to2",   32'(bus.HMASTER),   32'd2);
    chk("t3_d1",    32'(bus.HMASTER_D), 32'd1);
    chk("t3_model", 32'(m.own),         32'd2);
    tr[1] = 2'b00;

    // 4: locked singles on M2 block M0
    bu[2] = 3'b000; lk[2] = 1'b1; tr[0] = 2'b10;
    step();
    chk("t4_lock_own", 32'(bus.HMASTER),   32'd2);
    chk("t4_lock_out", 32'(bus.HMASTLOCK), 32'd1);
    step();
    chk("t4_lock_own2", 32'(bus.HMASTER), 32'd2);
    lk[2] = 1'b0; tr[2] = 2'b00;
    step();
    chk("t4_release", 32'(bus.HMASTER), 32'd0);

    // 5: M0 INCR8 with a 3-cycle wait state at beat 2
    bu[0] = 3'b101;
    step();
    tr[0] = 2'b11; tr[1] = 2'b10;
    step();
    hr = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk("t5_frozen",   32'(bus.HMASTER),     32'd0);
      chk("t5_ready_lo", 32'(bus.HREADYOUT_M), 32'b100);
    end
    hr = 1'b1;
    for (int b = 0; b < 6; b++) begin
      step();
      chk("t5_hold", 32'(bus.HMASTER), 32'd0);
    end
    chk("t5_model_left", 32'(m.left), 32'd0);
    tr[0] = 2'b00;
    step();
    chk("t5_switch", 32'(bus.HMASTER), 32'd1);

    // 6: WRAP4 cut short by IDLE after beat 2
    tr[1] = 2'b00; tr[0] = 2'b10; bu[0] = 3'b010;
    step();
    chk("t6_own0", 32'(bus.HMASTER), 32'd0);
    step();
    tr[0] = 2'b11; tr[1] = 2'b10;
    step();
    tr[0] = 2'b00;
    step();
    chk("t6_still0", 32'(bus.HMASTER), 32'd0);
    step();
    chk("t6_to1", 32'(bus.HMASTER), 32'd1);

    // 7: reset in the middle of an M1 INCR4
    bu[1] = 3'b011;
    step();
    tr[1] = 2'b11;
    step();
    HRESETn = 1'b0;
    step();
    chk("t7_hmaster",   32'(bus.HMASTER),   32'd0);
    chk("t7_hmaster_d", 32'(bus.HMASTER_D), 32'd0);
    chk("t7_model_cnt", 32'(m.left),        32'd0);
    HRESETn = 1'b1;
    all_idle();
    step();
    tr[1] = 2'b10;
    step();
    chk("t7_cnt_clear", 32'(bus.HMASTER), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        tr[i] = 2'($urandom_range(0, 3));
        bu[i] = 3'($urandom_range(0, 7));
        lk[i] = ($urandom_range(0, 9) == 0);
      end
      hr      = ($urandom_range(0, 4) != 0);
      HRESETn = ($urandom_range(0, 99) != 0);
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
